// File: rtl/imem_load_ctrl_if.sv
// Bundles the loader byte stream, the core fetch port and the instruction RAM port
// of imem_load_ctrl. The controller connects through the slave modport; the
// environment around it (loader, core, RAM) uses the master modport.
interface imem_load_ctrl_if #(
    parameter int AW = 6
);
    // loader side
    logic          load_start;
    logic [AW:0]   load_len;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    // core fetch side
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_instr;
    logic          cpu_stall;
    logic          cpu_restart;
    // RAM side
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;
    // status
    logic          load_busy;
    logic          load_err;

    modport slave (
        input  load_start, load_len, byte_valid, byte_data, cpu_addr, mem_rd,
        output byte_ready, cpu_instr, cpu_stall, cpu_restart,
               mem_addr, mem_we, mem_wd, load_busy, load_err
    );

    modport master (
        output load_start, load_len, byte_valid, byte_data, cpu_addr, mem_rd,
        input  byte_ready, cpu_instr, cpu_stall, cpu_restart,
               mem_addr, mem_we, mem_wd, load_busy, load_err
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction RAM owner: the core fetches combinationally in RUN; a byte-stream
// loader can take the RAM over, pack little-endian bytes into words, write them
// from word 0 upward and then pulse a core restart.
module imem_load_ctrl #(
    parameter int          DEPTH = 64,
    parameter int          AW    = $clog2(DEPTH),
    parameter logic [31:0] NOP   = 32'hE1A00000
) (
    input  logic             clk,
    input  logic             reset,
    imem_load_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_RUN, S_LOAD, S_WRITE, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [AW-1:0] word_cnt_q, word_cnt_d;
    logic [AW:0]   len_q, len_d;
    logic [31:0]   asm_q, asm_d;
    logic          err_q, err_d;

    logic          byte_ready;
    logic [31:0]   cpu_instr;
    logic          cpu_stall;
    logic          cpu_restart;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          load_busy;

    // State register and load bookkeeping; reset drops any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            asm_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            asm_q      <= asm_d;
            err_q      <= err_d;
        end
    end

    // Next-state and RAM/core port muxing; the core sees NOP whenever it is stalled.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        asm_d       = asm_q;
        err_d       = err_q;
        byte_ready  = 1'b0;
        cpu_instr   = NOP;
        cpu_stall   = 1'b1;
        cpu_restart = 1'b0;
        mem_addr    = word_cnt_q;
        mem_we      = 1'b0;
        load_busy   = 1'b0;
        case (state_q)
            S_RUN: begin
                cpu_stall = 1'b0;
                cpu_instr = bus.mem_rd;
                // word address; PC bits above the RAM size wrap
                mem_addr  = bus.cpu_addr[AW+1:2];
                if (bus.load_start) begin
                    if (bus.load_len == '0) begin
                        state_d = S_DONE;
                    end else if (bus.load_len > DEPTH_L) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        len_d      = bus.load_len;
                        byte_cnt_d = '0;
                        word_cnt_d = '0;
                        asm_d      = '0;
                        err_d      = 1'b0;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
                if (bus.byte_valid) begin
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                load_busy = 1'b1;
                if ({1'b0, word_cnt_q} == len_q - (AW+1)'(1)) begin
                    state_d = S_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + AW'(1);
                    state_d    = S_LOAD;
                end
            end
            S_DONE: begin
                cpu_restart = 1'b1;
                state_d     = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign bus.byte_ready  = byte_ready;
    assign bus.cpu_instr   = cpu_instr;
    assign bus.cpu_stall   = cpu_stall;
    assign bus.cpu_restart = cpu_restart;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_we      = mem_we;
    assign bus.mem_wd      = asm_q;
    assign bus.load_busy   = load_busy;
    assign bus.load_err    = err_q;

endmodule
